// File: rtl/minimax_mem_pkg.sv
// Shared encodings for the minimax single-port memory arbiter.
package minimax_mem_pkg;

    localparam int STREAK_W = 4;

    // Who owns the read data coming back from the RAM in the current cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/minimax_mem_arbiter.sv
// Arbitrates one single-port 1-cycle RAM between minimax fetch and data ports.
// Data has priority; fetch wins after D_MAX_STREAK data grants while it waits.
module minimax_mem_arbiter
    import minimax_mem_pkg::*;
#(
    parameter int AW           = 12,
    parameter int D_MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [15:0]   i_rdata,

    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wmask,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,

    output logic          mem_en,
    output logic [AW-3:0] mem_addr,
    output logic [3:0]    mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;
    owner_e              own_q;
    logic                hsel_q;
    logic [15:0]         i_rdata_q;
    logic [31:0]         d_rdata_q;
    logic                fetch_starved;
    logic [15:0]         i_half;

    // Address bits below the access granularity are intentionally unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[0], d_addr[1:0]};

    always_comb begin
        fetch_starved = i_req && (streak_q == STREAK_MAX);
        d_gnt         = reset_n && d_req && !fetch_starved;
        i_gnt         = reset_n && i_req && !d_gnt;
        mem_en        = i_gnt || d_gnt;
        mem_addr      = d_gnt ? d_addr[AW-1:2] : i_addr[AW-1:2];
        mem_we        = d_gnt ? d_wmask : 4'h0;
        mem_wdata     = d_wdata;
    end

    // Streak only grows while fetch is actually waiting behind data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else if (d_gnt && i_req) begin
            if (streak_q != STREAK_MAX)
                streak_q <= streak_q + 4'd1;
        end else begin
            streak_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            own_q  <= OWN_NONE;
            hsel_q <= 1'b0;
        end else begin
            if (i_gnt)
                own_q <= OWN_I;
            else if (d_gnt && (d_wmask == 4'h0))
                own_q <= OWN_D;
            else
                own_q <= OWN_NONE;
            if (i_gnt)
                hsel_q <= i_addr[1];
        end
    end

    // Gating with reset_n drops a response still in flight when reset hits
    assign i_rvalid = reset_n && (own_q == OWN_I);
    assign d_rvalid = reset_n && (own_q == OWN_D);
    assign i_half   = hsel_q ? mem_rdata[31:16] : mem_rdata[15:0];

    // Live RAM data in the rvalid cycle, held copy afterwards
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (i_rvalid)
                i_rdata_q <= i_half;
            if (d_rvalid)
                d_rdata_q <= mem_rdata;
        end
    end

    assign i_rdata = i_rvalid ? i_half    : i_rdata_q;
    assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_minimax_mem_arbiter.sv
// Self-checking bench for minimax_mem_arbiter: directed cases plus random traffic
// against a word-array reference model of the shared RAM.
module tb_minimax_mem_arbiter;

    localparam int AW    = 12;
    localparam int DMAX  = 4;
    localparam int DEPTH = 1 << (AW - 2);
    localparam int NW    = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [15:0]   i_rdata;
    logic          d_req, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic [3:0]    d_wmask;
    logic          mem_en;
    logic [AW-3:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    minimax_mem_arbiter #(.AW(AW), .D_MAX_STREAK(DMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Device-side RAM with a backdoor load port used only while in reset
    logic [31:0]   ram [DEPTH];
    logic [31:0]   ram_q;
    logic          bd_we;
    logic [AW-3:0] bd_addr;
    logic [31:0]   bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_en) begin
            ram_q <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = ram_q;

    // Reference model
    logic [31:0] ref_mem [DEPTH];
    int          errs = 0, checks = 0;
    int          streak_m, dwait;
    bit          exp_iv, exp_dv;
    logic [15:0] exp_ih, held_i;
    logic [31:0] exp_dw, held_d;

    typedef struct {
        logic ig, dg, iv, dv, men;
        logic [3:0]  mwe;
        logic [15:0] ird;
        logic [31:0] drd;
    } obs_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // One clock: inputs already driven; check at negedge, advance model, return after posedge
    task automatic step(output obs_t o);
        bit eg_i, eg_d, n_iv, n_dv;
        logic [15:0] n_ih;
        logic [31:0] n_dw, iw;
        @(negedge clk);
        o.ig = i_gnt; o.dg = d_gnt; o.iv = i_rvalid; o.dv = d_rvalid; o.men = mem_en;
        o.mwe = mem_we; o.ird = i_rdata; o.drd = d_rdata;

        eg_d = reset_n && d_req && !(i_req && streak_m >= DMAX);
        eg_i = reset_n && i_req && !eg_d;
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        chk("mem_en", mem_en, eg_i || eg_d);
        if (eg_d) begin
            chk("mem_addr_d", mem_addr, d_addr[AW-1:2]);
            chk("mem_we_d", mem_we, d_wmask);
            if (d_wmask != 4'h0) chk("mem_wdata", mem_wdata, d_wdata);
        end else begin
            chk("mem_we_0", mem_we, 4'h0);
            if (eg_i) chk("mem_addr_i", mem_addr, i_addr[AW-1:2]);
        end
        chk("i_rvalid", i_rvalid, exp_iv && reset_n);
        chk("d_rvalid", d_rvalid, exp_dv && reset_n);
        if (reset_n) begin
            chk("i_rdata", i_rdata, exp_iv ? exp_ih : held_i);
            chk("d_rdata", d_rdata, exp_dv ? exp_dw : held_d);
        end

        if (!reset_n) begin
            streak_m = 0; dwait = 0;
            exp_iv = 0; exp_dv = 0; held_i = '0; held_d = '0;
        end else begin
            if (exp_iv) held_i = exp_ih;
            if (exp_dv) held_d = exp_dw;
            iw   = ref_mem[i_addr[AW-1:2]];
            n_iv = eg_i;
            n_ih = i_addr[1] ? iw[31:16] : iw[15:0];
            n_dv = eg_d && (d_wmask == 4'h0);
            n_dw = ref_mem[d_addr[AW-1:2]];
            if (eg_d) ref_mem[d_addr[AW-1:2]] = merge(n_dw, d_wdata, d_wmask);
            streak_m = (eg_d && i_req) ? ((streak_m + 1 > DMAX) ? DMAX : streak_m + 1) : 0;
            exp_iv = n_iv; exp_ih = n_ih; exp_dv = n_dv; exp_dw = n_dw;
            // Fetch must never wait behind more than DMAX data grants
            if (i_req && o.dg) dwait++;
            if (o.ig) begin
                chk("starve", 32'(dwait <= DMAX), 32'd1);
                dwait = 0;
            end
            if (!i_req) dwait = 0;
        end
        @(posedge clk); #1;
    endtask

    obs_t o;

    initial begin
        reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        streak_m = 0; dwait = 0; exp_iv = 0; exp_dv = 0; held_i = '0; held_d = '0;
        exp_ih = '0; exp_dw = '0;

        @(posedge clk); #1;
        for (int w = 0; w < NW; w++) begin
            bd_we   = 1'b1;
            bd_addr = (AW-2)'(w);
            bd_data = (w == 1) ? 32'hBEEFCAFE : (w == 4) ? 32'hAABBCCDD : $urandom;
            ref_mem[w] = bd_data;
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        // Reset state, with requests pending that must not be granted
        i_req = 1'b1; d_req = 1'b1;
        step(o);
        chk("rst_gnt", {o.ig, o.dg, o.men}, 3'b000);
        i_req = 1'b0; d_req = 1'b0;
        reset_n = 1'b1;
        chk("rst_ird", i_rdata, 16'h0);
        chk("rst_drd", d_rdata, 32'h0);
        chk("rst_rv", {i_rvalid, d_rvalid}, 2'b00);

        // 1: fetch of upper halfword
        i_req = 1'b1; i_addr = 12'h006;
        step(o);
        chk("t1_gnt", o.ig, 1'b1);
        i_req = 1'b0;
        step(o);
        chk("t1_rv", o.iv, 1'b1);
        chk("t1_rd", o.ird, 16'hBEEF);
        chk("t1_drv", o.dv, 1'b0);

        // 2: partial write then read back
        d_req = 1'b1; d_addr = 12'h010; d_wmask = 4'h3; d_wdata = 32'h12345678;
        step(o);
        chk("t2_we", o.mwe, 4'h3);
        d_wmask = 4'h0;
        step(o);
        chk("t2_wr_norv", o.dv, 1'b0);
        chk("t2_rd_we", o.mwe, 4'h0);
        d_req = 1'b0;
        step(o);
        chk("t2_rv", o.dv, 1'b1);
        chk("t2_rd", o.drd, 32'hAABB5678);

        // 3: both requesting continuously -> DDDDI
        i_req = 1'b1; i_addr = 12'h000; d_req = 1'b1; d_addr = 12'h020;
        for (int k = 1; k <= 12; k++) begin
            step(o);
            chk("t3_ig", o.ig, (k % 5) == 0);
            chk("t3_dg", o.dg, (k % 5) != 0);
        end
        i_req = 1'b0; d_req = 1'b0;
        step(o);

        // 4: data reads alone, pipelined
        d_req = 1'b1; d_addr = 12'h00C;
        for (int k = 1; k <= 10; k++) begin
            step(o);
            chk("t4_dg", o.dg, 1'b1);
            chk("t4_dv", o.dv, k >= 2);
        end
        d_req = 1'b0;
        step(o);

        // 5: reset right after a fetch grant drops the response
        i_req = 1'b1; i_addr = 12'h004;
        step(o);
        chk("t5_gnt", o.ig, 1'b1);
        reset_n = 1'b0; d_req = 1'b1;
        step(o);
        chk("t5_norv", o.iv, 1'b0);
        chk("t5_rst_gnt", {o.ig, o.dg, o.men, o.mwe}, 7'h0);
        reset_n = 1'b1; d_req = 1'b0; i_req = 1'b1; i_addr = 12'h006;
        step(o);
        chk("t5_gnt2", o.ig, 1'b1);
        i_req = 1'b0;
        step(o);
        chk("t5_rv", o.iv, 1'b1);
        chk("t5_rd", o.ird, 16'hBEEF);

        // 6: random traffic, requesters hold until granted
        for (int n = 0; n < 10000; n++) begin
            step(o);
            reset_n = ($urandom_range(0, 499) != 0);
            if (!i_req || o.ig) begin
                i_req  = ($urandom_range(0, 99) < 60);
                i_addr = {4'h0, 6'($urandom_range(0, NW-1)), 2'($urandom)};
            end
            if (!d_req || o.dg) begin
                d_req   = ($urandom_range(0, 99) < 70);
                d_addr  = {4'h0, 6'($urandom_range(0, NW-1)), 2'($urandom)};
                d_wdata = $urandom;
                d_wmask = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
